// File: rtl/pad_mux_pkg.sv
// pad_mux_pkg: shared constants and helpers for the pad multiplexer.
//   - CFG_FSEL_LSB     : lsb of the fsel field in a pin config word
//   - cfg_filt_en_bit  : bit position of filt_en in a pin config word
//   - status_addr      : config address of the filtered pad status word
//   - clog2_min1       : $clog2 clamped to at least 1 (select width)
package pad_mux_pkg;

  localparam int CFG_FSEL_LSB = 0;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  // filt_en sits directly above the fsel field: {filt_en, fsel}.
  function automatic int cfg_filt_en_bit(input int fsel_w);
    return CFG_FSEL_LSB + fsel_w;
  endfunction

  // Pin config words occupy 0..npins-1; the status word follows them.
  function automatic int status_addr(input int npins);
    return npins;
  endfunction

endpackage

// File: rtl/pad_in_filter.sv
// pad_in_filter: per-pad input conditioning.
//   SYNC_STAGES-flop synchroniser followed by an optional debounce filter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   filt_en   : 1 = debounce enabled, 0 = filt_o follows the synchronised pad
//   pad_i     : asynchronous pad input
//   filt_o    : conditioned (registered) pad level
module pad_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic filt_en,
  input  logic pad_i,
  output logic filt_o
);

  // The counter reaching FILT_MAX-1 while still differing is the
  // FILT_MAX-th consecutive differing cycle, so the new level is taken then.
  localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'((2 ** FILT_W) - 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [FILT_W-1:0]      cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      filt_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      if (!filt_en) begin
        filt_o <= sync;
        cnt    <= '0;
      end else if (sync != filt_o) begin
        if (cnt == CNT_LAST) begin
          filt_o <= sync;
          cnt    <= '0;
        end else begin
          cnt <= cnt + FILT_W'(1);
        end
      end else begin
        // Any agreeing cycle restarts the run of differing cycles.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pad_mux_ctrl.sv
// pad_mux_ctrl: run-time configurable pad multiplexer.
//   Each pad is routed to one of NFUNC peripheral functions by a per-pin
//   select register. Output enable is forced low for BBM_CYC cycles after a
//   select change (break-before-make). Pad inputs are synchronised and may be
//   debounced per pin.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cfg_req/we/addr/wdata : config access; addr 0..NPINS-1 = pin {filt_en,fsel},
//                           addr NPINS = filtered pad status (read only)
//   cfg_rdata, cfg_rvalid : read response
//   func_o, func_oe       : peripheral outputs/enables, bit p*NFUNC+f
//   func_i                : peripheral inputs, same indexing
//   pad_o, pad_oe, pad_i  : pad ring side
// Config handshake: there is no backpressure; every cycle with cfg_req high
// is one access. A read (cfg_we=0) returns cfg_rdata with a single-cycle
// cfg_rvalid pulse on the following cycle; writes give no response.
module pad_mux_ctrl
  import pad_mux_pkg::*;
#(
  parameter int NPINS       = 8,
  parameter int NFUNC       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int BBM_CYC     = 2,
  parameter logic [NPINS*clog2_min1(NFUNC)-1:0] RST_FSEL = '0,
  localparam int FSEL_W  = clog2_min1(NFUNC),
  localparam int ADDR_W  = $clog2(NPINS + 1),
  localparam int RDATA_W = (FSEL_W + 1 > NPINS) ? FSEL_W + 1 : NPINS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_req,
  input  logic                   cfg_we,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [FSEL_W:0]        cfg_wdata,
  output logic [RDATA_W-1:0]     cfg_rdata,
  output logic                   cfg_rvalid,
  input  logic [NPINS*NFUNC-1:0] func_o,
  input  logic [NPINS*NFUNC-1:0] func_oe,
  output logic [NPINS*NFUNC-1:0] func_i,
  output logic [NPINS-1:0]       pad_o,
  output logic [NPINS-1:0]       pad_oe,
  input  logic [NPINS-1:0]       pad_i
);

  localparam int BBM_W  = $clog2(BBM_CYC + 1);
  localparam int FE_BIT = cfg_filt_en_bit(FSEL_W);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_addr(NPINS));

  logic [FSEL_W-1:0]  fsel_q  [NPINS];
  logic [BBM_W-1:0]   bbm_cnt [NPINS];
  logic [NPINS-1:0]   filt_en_q;
  logic [NPINS-1:0]   filt;
  logic [FSEL_W-1:0]  wr_fsel;
  logic               wr_filt_en;
  logic               wr_ok;
  logic               rd_req;
  logic [RDATA_W-1:0] rd_mux;

  assign wr_fsel    = cfg_wdata[CFG_FSEL_LSB +: FSEL_W];
  assign wr_filt_en = cfg_wdata[FE_BIT];
  // An out-of-range select drops the whole write, filt_en included.
  assign wr_ok  = cfg_req && cfg_we && (cfg_addr < STATUS_ADDR) && (int'(wr_fsel) < NFUNC);
  assign rd_req = cfg_req && !cfg_we;

  always_comb begin
    rd_mux = '0;
    if (cfg_addr == STATUS_ADDR) begin
      rd_mux = RDATA_W'(filt);
    end else begin
      for (int p = 0; p < NPINS; p++) begin
        if (cfg_addr == ADDR_W'(p)) rd_mux = RDATA_W'({filt_en_q[p], fsel_q[p]});
      end
    end
  end

  // Only the selected function sees the pad; the others read 0.
  always_comb begin
    func_i = '0;
    for (int p = 0; p < NPINS; p++) begin
      for (int f = 0; f < NFUNC; f++) begin
        if (fsel_q[p] == FSEL_W'(f)) func_i[p*NFUNC + f] = filt[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPINS; p++) begin
        fsel_q[p]  <= RST_FSEL[p*FSEL_W +: FSEL_W];
        bbm_cnt[p] <= '0;
      end
      filt_en_q  <= '0;
      pad_o      <= '0;
      pad_oe     <= '0;
      cfg_rdata  <= '0;
      cfg_rvalid <= 1'b0;
    end else begin
      for (int p = 0; p < NPINS; p++) begin
        pad_o[p]  <= func_o[p*NFUNC + int'(fsel_q[p])];
        pad_oe[p] <= func_oe[p*NFUNC + int'(fsel_q[p])] && (bbm_cnt[p] == '0);
        if (wr_ok && cfg_addr == ADDR_W'(p)) begin
          fsel_q[p]    <= wr_fsel;
          filt_en_q[p] <= wr_filt_en;
        end
        // A real select change (re)starts the enable gap; rewriting the
        // current select leaves the pad undisturbed.
        if (wr_ok && cfg_addr == ADDR_W'(p) && wr_fsel != fsel_q[p]) begin
          bbm_cnt[p] <= BBM_W'(BBM_CYC);
        end else if (bbm_cnt[p] != '0) begin
          bbm_cnt[p] <= bbm_cnt[p] - BBM_W'(1);
        end
      end
      cfg_rvalid <= rd_req;
      cfg_rdata  <= rd_req ? rd_mux : '0;
    end
  end

  for (genvar p = 0; p < NPINS; p++) begin : g_pin
    pad_in_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W)
    ) u_filt (
      .clk    (clk),
      .rst    (rst),
      .filt_en(filt_en_q[p]),
      .pad_i  (pad_i[p]),
      .filt_o (filt[p])
    );
  end

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Bench for pad_mux_ctrl: reset, table of config vectors, hand-written
// multi-cycle sequences (break-before-make, invalid select, debounce,
// latency, mid-operation reset) and a randomized run against a reference
// model built from select/change-time bookkeeping and a pad history.
module tb_pad_mux_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_req = 1'b0, cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [2:0]  cfg_wdata = '0;
  logic [7:0]  cfg_rdata;
  logic        cfg_rvalid;
  logic [31:0] func_o = '0, func_oe = '0;
  logic [31:0] func_i;
  logic [7:0]  pad_o, pad_oe;
  logic [7:0]  pad_i = '0;

  // Second instance with a non-power-of-two function count, so that an
  // out-of-range select value is encodable.
  logic        c3_req = 1'b0, c3_we = 1'b0;
  logic [3:0]  c3_addr = '0;
  logic [2:0]  c3_wdata = '0;
  logic [7:0]  c3_rdata;
  logic        c3_rvalid;
  logic [23:0] c3_func_o = '0, c3_func_oe = '0;
  logic [23:0] c3_func_i;
  logic [7:0]  c3_pad_o, c3_pad_oe;
  logic [7:0]  c3_pad_i = '0;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  pad_mux_ctrl dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .func_o(func_o), .func_oe(func_oe), .func_i(func_i),
    .pad_o(pad_o), .pad_oe(pad_oe), .pad_i(pad_i)
  );

  pad_mux_ctrl #(.NFUNC(3)) dut3 (
    .clk(clk), .rst(rst), .cfg_req(c3_req), .cfg_we(c3_we), .cfg_addr(c3_addr),
    .cfg_wdata(c3_wdata), .cfg_rdata(c3_rdata), .cfg_rvalid(c3_rvalid),
    .func_o(c3_func_o), .func_oe(c3_func_oe), .func_i(c3_func_i),
    .pad_o(c3_pad_o), .pad_oe(c3_pad_oe), .pad_i(c3_pad_i)
  );

  typedef struct {
    logic       req;
    logic       we;
    logic [3:0] addr;
    logic [2:0] wdata;
    logic       exp_rvalid;
    logic [7:0] exp_rdata;
  } cfg_vec_t;

  cfg_vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [2:0] d);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  // ---------------- reference model for the randomized run ----------------
  logic [1:0] m_fsel [8];
  int         last_chg [8];
  logic [7:0] hist [$];

  function automatic logic [7:0] pad_at(input int e);
    if (e < 0 || e >= hist.size()) return 8'h00;
    return hist[e];
  endfunction

  task automatic run_random(input int n);
    logic [31:0] fo, foe, exp_fi;
    logic [7:0]  pi, exp_o, exp_oe, exp_rd, filt;
    logic        rq, we, exp_rv, gap;
    logic [3:0]  ad;
    logic [1:0]  fs;
    int          idx;
    for (int p = 0; p < 8; p++) begin
      m_fsel[p]   = 2'd0;
      last_chg[p] = -100;
    end
    for (int k = 0; k < n; k++) begin
      fo  = $urandom;
      foe = $urandom;
      pi  = 8'($urandom_range(0, 255));
      rq  = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      ad  = 4'($urandom_range(0, 15));
      fs  = 2'($urandom_range(0, 3));
      func_o = fo; func_oe = foe; pad_i = pi;
      cfg_req = rq; cfg_we = we; cfg_addr = ad; cfg_wdata = {1'b0, fs};
      // Outputs after this edge use the select held before it; the enable
      // is suppressed on the BBM_CYC edges following a select change.
      for (int p = 0; p < 8; p++) begin
        idx = p * 4 + int'(m_fsel[p]);
        gap = (k > last_chg[p]) && (k - last_chg[p] <= 2);
        exp_o[p]  = fo[idx];
        exp_oe[p] = foe[idx] & ~gap;
      end
      exp_rv = rq & ~we;
      if (ad < 4'd8)       exp_rd = {6'd0, m_fsel[ad[2:0]]};
      else if (ad == 4'd8) exp_rd = pad_at(k - 3);
      else                 exp_rd = 8'h00;
      if (rq && we && ad < 4'd8) begin
        if (fs != m_fsel[ad[2:0]]) last_chg[ad[2:0]] = k;
        m_fsel[ad[2:0]] = fs;
      end
      hist.push_back(pi);
      tick();
      filt   = pad_at(k - 2);
      exp_fi = '0;
      for (int p = 0; p < 8; p++)
        for (int f = 0; f < 4; f++)
          if (f == int'(m_fsel[p])) exp_fi[p*4 + f] = filt[p];
      check("rnd_pad_o", pad_o, exp_o);
      check("rnd_pad_oe", pad_oe, exp_oe);
      check("rnd_func_i", func_i, exp_fi);
      check("rnd_rvalid", cfg_rvalid, exp_rv);
      if (exp_rv) check("rnd_rdata", cfg_rdata, exp_rd);
    end
    cfg_req = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    check("rst_pad_o", pad_o, 8'h00);
    check("rst_pad_oe", pad_oe, 8'h00);
    check("rst_func_i", func_i, 32'h0);
    check("rst_rvalid", cfg_rvalid, 1'b0);
    check("rst_rdata", cfg_rdata, 8'h00);
    rst = 1'b0;
    func_o  = 32'h1111_1111;
    func_oe = 32'h1111_1111;
    tick();
    check("f0_pad_o", pad_o, 8'hFF);
    check("f0_pad_oe", pad_oe, 8'hFF);

    // ---------------- break-before-make on pin 3 ----------------
    func_o  = 32'h1111_4111;   // pin3: f0 drives 0, f2 drives 1
    func_oe = 32'h1111_5111;   // pin3: f0 and f2 enabled
    cfg_write(4'd3, 3'b010);
    tick();
    check("bbm_gap1", pad_oe, 8'hF7);
    tick();
    check("bbm_gap2", pad_oe, 8'hF7);
    tick();
    check("bbm_end_oe", pad_oe, 8'hFF);
    check("bbm_end_o", pad_o, 8'hFF);
    cfg_write(4'd3, 3'b010);
    check("same_w0", pad_oe, 8'hFF);
    tick();
    check("same_w1", pad_oe, 8'hFF);
    tick();
    check("same_w2", pad_oe, 8'hFF);

    // ---------------- config vector table ----------------
    tbl[0]  = '{1'b1, 1'b1, 4'd1,  3'b011, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 4'd1,  3'b000, 1'b1, 8'h03};
    tbl[2]  = '{1'b1, 1'b1, 4'd2,  3'b101, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 4'd2,  3'b000, 1'b1, 8'h05};
    tbl[4]  = '{1'b1, 1'b1, 4'd9,  3'b001, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 4'd9,  3'b000, 1'b1, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 4'd8,  3'b000, 1'b1, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 4'd15, 3'b000, 1'b1, 8'h00};
    tbl[8]  = '{1'b1, 1'b1, 4'd7,  3'b010, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 4'd7,  3'b000, 1'b1, 8'h02};
    tbl[10] = '{1'b1, 1'b0, 4'd3,  3'b000, 1'b1, 8'h02};
    tbl[11] = '{1'b0, 1'b0, 4'd3,  3'b000, 1'b0, 8'h00};
    tbl[12] = '{1'b1, 1'b1, 4'd8,  3'b011, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 1'b0, 4'd0,  3'b000, 1'b1, 8'h00};
    for (int i = 0; i < 14; i++) begin
      cfg_req = tbl[i].req; cfg_we = tbl[i].we;
      cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wdata;
      tick();
      check($sformatf("tbl%0d_rvalid", i), cfg_rvalid, tbl[i].exp_rvalid);
      if (tbl[i].exp_rvalid) check($sformatf("tbl%0d_rdata", i), cfg_rdata, tbl[i].exp_rdata);
    end
    cfg_req = 1'b0;

    // ---------------- out-of-range select dropped (NFUNC=3) ----------------
    c3_req = 1'b1; c3_we = 1'b1; c3_addr = 4'd0; c3_wdata = 3'b001;
    tick();
    c3_wdata = 3'b111;
    tick();
    c3_we = 1'b0;
    tick();
    check("inv_rvalid", c3_rvalid, 1'b1);
    check("inv_rdata", c3_rdata, 8'h01);
    c3_req = 1'b0;
    tick();
    check("inv_rvalid_pulse", c3_rvalid, 1'b0);
    check("c3_quiet", {c3_pad_o, c3_pad_oe, c3_func_i}, 40'h0);

    // ---------------- debounce on pin 4 ----------------
    cfg_write(4'd4, 3'b100);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd8;
    pad_i[4] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check("glitch_hi", func_i[16], 1'b0);
    end
    pad_i[4] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      check("glitch_lo", func_i[16], 1'b0);
    end
    pad_i[4] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      check($sformatf("hold_n%0d", n), func_i[16], (n >= 17));
      if (n == 17) check("status_pre", cfg_rdata, 8'h00);
      if (n == 18) check("status_post", cfg_rdata, 8'h10);
    end
    // Disabling the filter mid-count: filt follows sync on the next cycle.
    pad_i[4] = 1'b0;
    for (int n = 1; n <= 8; n++) tick();
    cfg_write(4'd4, 3'b000);
    check("fdis_hold", func_i[16], 1'b1);
    tick();
    check("fdis_follow", func_i[16], 1'b0);

    // ---------------- unfiltered latency on pin 5 ----------------
    cfg_write(4'd5, 3'b001);
    pad_i[5] = 1'b1;
    tick();
    check("lat_rise1", func_i[23:20], 4'b0000);
    tick();
    check("lat_rise2", func_i[23:20], 4'b0000);
    tick();
    check("lat_rise3", func_i[23:20], 4'b0010);
    pad_i[5] = 1'b0;
    tick();
    tick();
    check("lat_fall2", func_i[23:20], 4'b0010);
    tick();
    check("lat_fall3", func_i[23:20], 4'b0000);

    // ---------------- reset mid-bbm / mid-filter / pending read ----------------
    pad_i[7] = 1'b1;
    cfg_write(4'd4, 3'b100);
    pad_i[4] = 1'b1;
    tick();
    tick();
    check("pre_rst_pin7", func_i[30], 1'b1);
    cfg_write(4'd6, 3'b001);
    rst = 1'b1;
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd6;
    tick();
    check("mid_rst_pad_o", pad_o, 8'h00);
    check("mid_rst_pad_oe", pad_oe, 8'h00);
    check("mid_rst_func_i", func_i, 32'h0);
    check("mid_rst_rvalid", cfg_rvalid, 1'b0);
    check("mid_rst_rdata", cfg_rdata, 8'h00);
    rst = 1'b0;
    pad_i = '0;
    func_o  = 32'h1111_1111;
    func_oe = 32'h1111_1111;
    tick();
    check("post_rst_pad_o", pad_o, 8'hFF);
    check("post_rst_pad_oe", pad_oe, 8'hFF);
    check("post_rst_rvalid", cfg_rvalid, 1'b1);
    check("post_rst_fsel6", cfg_rdata, 8'h00);
    check("post_rst_func_i", func_i, 32'h0);

    // ---------------- randomized run ----------------
    run_random(400);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
